pe_ws_dbuf: RTL and testbench

Next-generation weight-stationary processing element for the systolic array. Adds the following over the single-register PE:
- Double-buffered weight: a shadow register filled by a column shift chain, swapped into the active register on command.
- Registered activation forwarding to the right neighbour.
- Registered partial-sum accumulation to the lower neighbour.
- Signed/unsigned mode, optional saturation, and a global pipeline stall.

Tiles into an R x C grid. Activations flow east, weights and partial sums flow south.

---
 rtl/pe_ws_dbuf_if.sv | 38 +++
 rtl/pe_ws_dbuf.sv | 137 +++++++++++++
 tb/tb_pe_ws_dbuf.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ws_dbuf_if.sv
// Bus bundle for one weight-stationary PE: weight column chain, activation
// row chain, partial-sum column chain and the global control strobes.
interface pe_ws_dbuf_if #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_ACC = 40
);
  logic                 pipeline_en;
  logic                 clear;
  logic [WIDTH_B-1:0]   w_in;
  logic                 w_load_in;
  logic [WIDTH_B-1:0]   w_out;
  logic                 w_load_out;
  logic                 w_swap_in;
  logic                 w_swap_out;
  logic [WIDTH_A-1:0]   a_in;
  logic                 a_valid_in;
  logic [WIDTH_A-1:0]   a_out;
  logic                 a_valid_out;
  logic [WIDTH_ACC-1:0] psum_in;
  logic [WIDTH_ACC-1:0] psum_out;
  logic                 psum_valid_out;
  logic                 sat_flag;

  modport master (
    output pipeline_en, clear, w_in, w_load_in, w_swap_in,
           a_in, a_valid_in, psum_in,
    input  w_out, w_load_out, w_swap_out, a_out, a_valid_out,
           psum_out, psum_valid_out, sat_flag
  );

  modport slave (
    input  pipeline_en, clear, w_in, w_load_in, w_swap_in,
           a_in, a_valid_in, psum_in,
    output w_out, w_load_out, w_swap_out, a_out, a_valid_out,
           psum_out, psum_valid_out, sat_flag
  );
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with double-buffered weight. The shadow register is
// filled through the column shift chain while the active register keeps
// feeding the MAC; a swap copies shadow into active. Single-cycle MAC with
// signed/unsigned operands and optional saturation on the partial sum.
module pe_ws_dbuf #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_ACC = 40,
  parameter int SIGNED    = 1,
  parameter int SAT_EN    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pe_ws_dbuf_if.slave   bus
);
  localparam int   PW  = WIDTH_A + WIDTH_B;
  localparam int   SW  = WIDTH_ACC + 1;
  localparam logic SX  = (SIGNED != 0);
  localparam logic SAT = (SAT_EN != 0);

  if (WIDTH_ACC < PW) begin : g_width_chk
    $error("pe_ws_dbuf: WIDTH_ACC must be >= WIDTH_A + WIDTH_B");
  end

  // Overflow of the one-bit-wider sum: signed uses the top two bits,
  // unsigned uses the carry bit.
  function automatic logic ovf_fn(input logic signed [SW-1:0] s);
    if (SX) return s[SW-1] ^ s[SW-2];
    return s[SW-1];
  endfunction

  // Clamp to the representable range on overflow, otherwise keep the low bits.
  function automatic logic [WIDTH_ACC-1:0] sat_fn(input logic signed [SW-1:0] s,
                                                   input logic ovf);
    if (!ovf || !SAT) return s[WIDTH_ACC-1:0];
    if (SX) return s[SW-1] ? {1'b1, {(WIDTH_ACC-1){1'b0}}}
                           : {1'b0, {(WIDTH_ACC-1){1'b1}}};
    return '1;
  endfunction

  logic [WIDTH_B-1:0]   shadow_q, shadow_d;
  logic [WIDTH_B-1:0]   act_q, act_d;
  logic                 w_load_q, w_load_d;
  logic                 w_swap_q, w_swap_d;
  logic [WIDTH_A-1:0]   a_q, a_d;
  logic                 a_vld_q, a_vld_d;
  logic [WIDTH_ACC-1:0] psum_q, psum_d;
  logic                 psum_vld_q, psum_vld_d;
  logic                 sat_q, sat_d;

  logic signed [PW-1:0] a_x, w_x, prod;
  logic signed [SW-1:0] prod_x, psum_x, sum;
  logic                 ovf;
  logic [WIDTH_ACC-1:0] mac_res;

  // MAC datapath: operands extended to the full product width so the
  // modular multiply is exact, then product and psum_in widened by one bit.
  always_comb begin
    a_x     = {{(PW-WIDTH_A){SX & bus.a_in[WIDTH_A-1]}}, bus.a_in};
    w_x     = {{(PW-WIDTH_B){SX & act_q[WIDTH_B-1]}}, act_q};
    prod    = a_x * w_x;
    prod_x  = {{(SW-PW){SX & prod[PW-1]}}, prod};
    psum_x  = {SX & bus.psum_in[WIDTH_ACC-1], bus.psum_in};
    sum     = prod_x + psum_x;
    ovf     = ovf_fn(sum);
    mac_res = sat_fn(sum, ovf);
  end

  // Next-state: everything holds unless the pipeline advances; clear wipes
  // only the partial-sum side and wins over a valid activation.
  always_comb begin
    shadow_d   = shadow_q;
    act_d      = act_q;
    w_load_d   = w_load_q;
    w_swap_d   = w_swap_q;
    a_d        = a_q;
    a_vld_d    = a_vld_q;
    psum_d     = psum_q;
    psum_vld_d = psum_vld_q;
    sat_d      = sat_q;
    if (bus.pipeline_en) begin
      w_load_d = bus.w_load_in;
      w_swap_d = bus.w_swap_in;
      if (bus.w_load_in) shadow_d = bus.w_in;
      // Swap takes the shadow value from before this edge.
      if (bus.w_swap_in) act_d = shadow_q;
      a_d = bus.a_in;
      if (bus.clear) begin
        a_vld_d    = 1'b0;
        psum_vld_d = 1'b0;
        psum_d     = '0;
        sat_d      = 1'b0;
      end else begin
        a_vld_d    = bus.a_valid_in;
        psum_vld_d = bus.a_valid_in;
        if (bus.a_valid_in) begin
          psum_d = mac_res;
          sat_d  = sat_q | ovf;
        end
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      act_q      <= '0;
      w_load_q   <= 1'b0;
      w_swap_q   <= 1'b0;
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      act_q      <= act_d;
      w_load_q   <= w_load_d;
      w_swap_q   <= w_swap_d;
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.w_out          = shadow_q;
  assign bus.w_load_out     = w_load_q;
  assign bus.w_swap_out     = w_swap_q;
  assign bus.a_out          = a_q;
  assign bus.a_valid_out    = a_vld_q;
  assign bus.psum_out       = psum_q;
  assign bus.psum_valid_out = psum_vld_q;
  assign bus.sat_flag       = sat_q;
endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Bench for pe_ws_dbuf: three instances (signed+sat, signed+wrap,
// unsigned+sat) share one stimulus and are compared to an arithmetic model.
module tb_pe_ws_dbuf;
  localparam int WA = 16, WB = 16, WACC = 40, VW = WACC + WA + WB + 5;
  localparam longint SMAX = (longint'(1) <<< (WACC-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (WACC-1));
  localparam longint UMAX = (longint'(1) <<< WACC) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            en = 0, clr = 0, wl = 0, ws = 0, av = 0;
  logic [WB-1:0]   w = '0;
  logic [WA-1:0]   a = '0;
  logic [WACC-1:0] ps = '0;

  logic [WACC-1:0] o_ps [3];
  logic            o_pv [3], o_sat [3], o_av [3], o_wl [3], o_ws [3];
  logic [WA-1:0]   o_a [3];
  logic [WB-1:0]   o_w [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    pe_ws_dbuf_if #(.WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_ACC(WACC)) bus ();
    assign bus.pipeline_en = en;
    assign bus.clear       = clr;
    assign bus.w_in        = w;
    assign bus.w_load_in   = wl;
    assign bus.w_swap_in   = ws;
    assign bus.a_in        = a;
    assign bus.a_valid_in  = av;
    assign bus.psum_in     = ps;
    pe_ws_dbuf #(.WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_ACC(WACC),
                 .SIGNED((g == 2) ? 0 : 1), .SAT_EN((g == 1) ? 0 : 1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
    assign o_ps[g]  = bus.psum_out;
    assign o_pv[g]  = bus.psum_valid_out;
    assign o_sat[g] = bus.sat_flag;
    assign o_a[g]   = bus.a_out;
    assign o_av[g]  = bus.a_valid_out;
    assign o_w[g]   = bus.w_out;
    assign o_wl[g]  = bus.w_load_out;
    assign o_ws[g]  = bus.w_swap_out;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [WB-1:0]   m_shadow, m_active;
  logic            m_wl, m_ws, m_av, m_pv;
  logic [WA-1:0]   m_a;
  logic [WACC-1:0] m_ps [3];
  logic            m_sat [3];

  function automatic void model_reset();
    m_shadow = '0; m_active = '0; m_wl = 0; m_ws = 0; m_av = 0; m_pv = 0; m_a = '0;
    for (int c = 0; c < 3; c++) begin m_ps[c] = '0; m_sat[c] = 0; end
  endfunction

  // Config 0: signed clamp, 1: signed wrap, 2: unsigned clamp.
  function automatic void mac(input int c, output logic [WACC-1:0] r, output logic o);
    longint s;
    if (c == 2) begin
      s = longint'(ps) + longint'(a) * longint'(m_active);
      o = (s > UMAX);
      r = o ? WACC'(UMAX) : WACC'(s);
    end else begin
      s = longint'($signed(ps)) + longint'($signed(a)) * longint'($signed(m_active));
      o = (s > SMAX) || (s < SMIN);
      if (o && c == 0) r = (s > SMAX) ? WACC'(SMAX) : WACC'(SMIN);
      else r = WACC'(s);
    end
  endfunction

  function automatic logic [VW-1:0] got_v(input int c);
    return {o_ps[c], o_pv[c], o_sat[c], o_a[c], o_av[c], o_w[c], o_wl[c], o_ws[c]};
  endfunction

  function automatic logic [VW-1:0] exp_v(input int c);
    return {m_ps[c], m_pv, m_sat[c], m_a, m_av, m_shadow, m_wl, m_ws};
  endfunction

  // One clock: update the model from the inputs seen at the edge, then
  // settle 1 time unit so the caller samples away from the edge.
  task automatic step();
    logic [WACC-1:0] r;
    logic o;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (en) begin
      for (int c = 0; c < 3; c++) begin
        if (clr) begin m_ps[c] = '0; m_sat[c] = 0; end
        else if (av) begin
          mac(c, r, o);
          m_ps[c] = r;
          if (o) m_sat[c] = 1;
        end
      end
      m_pv = av && !clr;
      m_av = av && !clr;
      m_a  = a;
      if (ws) m_active = m_shadow;
      if (wl) m_shadow = w;
      m_wl = wl;
      m_ws = ws;
    end
    #1;
  endtask

  task automatic load_weight(input logic [WB-1:0] val);
    av = 0; w = val; wl = 1; ws = 0; step();
    wl = 0; ws = 1; step();
    ws = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    step(); step();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (got_v(c) !== '0)
        begin errors++; $display("FAIL reset_state[%0d] got %h want 0", c, got_v(c)); end
    end
    rst_n = 1;
    en = 1;
  endtask

  task automatic test_load_mac();
    load_weight(16'd5);
    a = 16'd3; ps = 40'd10; av = 1; step();
    av = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_ps[c] !== 40'd25 || o_pv[c] !== 1'b1)
        begin errors++; $display("FAIL load_mac_psum[%0d] got %0d/%0b want 25/1", c, o_ps[c], o_pv[c]); end
    end
    checks++;
    if (o_a[0] !== 16'd3 || o_w[0] !== 16'd5)
      begin errors++; $display("FAIL load_mac_fwd got a=%0d w=%0d want a=3 w=5", o_a[0], o_w[0]); end
  endtask

  task automatic test_double_buffer();
    a = 16'd4; ps = '0; av = 1; w = 16'hFFFE; wl = 1; step();
    wl = 0;
    checks++;
    if (o_ps[0] !== 40'd20 || o_w[0] !== 16'hFFFE)
      begin errors++; $display("FAIL dbuf_preload got %0d w=%h want 20 w=fffe", o_ps[0], o_w[0]); end
    step();
    checks++;
    if (o_ps[1] !== 40'd20)
      begin errors++; $display("FAIL dbuf_hold got %0d want 20", o_ps[1]); end
    ws = 1; step();
    ws = 0;
    checks++;
    if (o_ps[0] !== 40'd20 || o_ws[0] !== 1'b1)
      begin errors++; $display("FAIL dbuf_swap_edge got %0d/%0b want 20/1", o_ps[0], o_ws[0]); end
    step();
    av = 0;
    checks++;
    if (o_ps[0] !== 40'hFF_FFFF_FFF8 || o_ps[1] !== 40'hFF_FFFF_FFF8)
      begin errors++; $display("FAIL dbuf_after_swap got %h/%h want fffffffff8", o_ps[0], o_ps[1]); end
    checks++;
    if (o_ps[2] !== 40'd262136)
      begin errors++; $display("FAIL dbuf_after_swap_u got %0d want 262136", o_ps[2]); end
  endtask

  task automatic test_saturation();
    load_weight(16'd1);
    ps = 40'h7F_FFFF_FFFF; a = 16'd1; av = 1; step();
    checks++;
    if (o_ps[0] !== 40'h7F_FFFF_FFFF || o_sat[0] !== 1'b1)
      begin errors++; $display("FAIL sat_pos_clamp got %h/%0b want 7fffffffff/1", o_ps[0], o_sat[0]); end
    checks++;
    if (o_ps[1] !== 40'h80_0000_0000 || o_sat[1] !== 1'b1)
      begin errors++; $display("FAIL sat_pos_wrap got %h/%0b want 8000000000/1", o_ps[1], o_sat[1]); end
    checks++;
    if (o_ps[2] !== 40'h80_0000_0000 || o_sat[2] !== 1'b0)
      begin errors++; $display("FAIL sat_pos_unsigned got %h/%0b want 8000000000/0", o_ps[2], o_sat[2]); end
    ps = 40'h80_0000_0000; a = 16'hFFFF; step();
    checks++;
    if (o_ps[0] !== 40'h80_0000_0000 || o_ps[1] !== 40'h7F_FFFF_FFFF)
      begin errors++; $display("FAIL sat_neg got %h/%h want 8000000000/7fffffffff", o_ps[0], o_ps[1]); end
    checks++;
    if (o_ps[2] !== 40'h80_0000_FFFF || o_sat[2] !== 1'b0)
      begin errors++; $display("FAIL sat_neg_unsigned got %h/%0b want 800000ffff/0", o_ps[2], o_sat[2]); end
    ps = 40'hFF_FFFF_FFFF; a = 16'd2; step();
    av = 0;
    checks++;
    if (o_ps[2] !== 40'hFF_FFFF_FFFF || o_sat[2] !== 1'b1 || o_ps[0] !== 40'd1)
      begin errors++; $display("FAIL sat_unsigned_ovf got %h/%0b s=%h want ffffffffff/1 s=1", o_ps[2], o_sat[2], o_ps[0]); end
  endtask

  task automatic test_unsigned();
    clr = 1; step();
    clr = 0;
    load_weight(16'hFFFF);
    a = 16'hFFFF; ps = '0; av = 1; step();
    av = 0;
    checks++;
    if (o_ps[2] !== 40'h00_FFFE_0001 || o_sat[2] !== 1'b0)
      begin errors++; $display("FAIL unsigned_mul got %h/%0b want 00fffe0001/0", o_ps[2], o_sat[2]); end
    checks++;
    if (o_ps[0] !== 40'd1 || o_sat[0] !== 1'b0)
      begin errors++; $display("FAIL signed_mul_m1 got %h/%0b want 1/0", o_ps[0], o_sat[0]); end
  endtask

  task automatic test_stall();
    a = 16'd7; ps = 40'd100; av = 1; step();
    en = 0; clr = 1; wl = 1; ws = 1;
    for (int i = 0; i < 3; i++) begin
      a = WA'($urandom); w = WB'($urandom); av = $urandom_range(0, 1); ps = {8'($urandom), $urandom};
      step();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (got_v(c) !== exp_v(c))
          begin errors++; $display("FAIL stall_hold[%0d] cyc %0d got %h want %h", c, i, got_v(c), exp_v(c)); end
      end
    end
    checks++;
    if (o_ps[0] !== 40'd93)
      begin errors++; $display("FAIL stall_value got %0d want 93", o_ps[0]); end
    en = 1; clr = 0; wl = 0; ws = 0; a = 16'd5; ps = 40'd1; av = 1; step();
    av = 0;
    checks++;
    if (o_ps[0] !== 40'hFF_FFFF_FFFC || o_pv[0] !== 1'b1)
      begin errors++; $display("FAIL stall_resume got %h/%0b want fffffffffc/1", o_ps[0], o_pv[0]); end
  endtask

  task automatic test_clear();
    load_weight(16'd3);
    ps = 40'h7F_FFFF_FFFF; a = 16'd1; av = 1; step();
    checks++;
    if (o_sat[0] !== 1'b1)
      begin errors++; $display("FAIL clear_pre_sat got %0b want 1", o_sat[0]); end
    clr = 1; step();
    clr = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_ps[c] !== '0 || o_sat[c] !== 1'b0 || o_pv[c] !== 1'b0 || o_av[c] !== 1'b0)
        begin errors++; $display("FAIL clear_state[%0d] got ps=%h sat=%0b pv=%0b av=%0b want 0", c, o_ps[c], o_sat[c], o_pv[c], o_av[c]); end
    end
    a = 16'd2; ps = '0; step();
    av = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_ps[c] !== 40'd6)
        begin errors++; $display("FAIL clear_keeps_weight[%0d] got %0d want 6", c, o_ps[c]); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      a = WA'($urandom); w = WB'($urandom); wl = 1; ws = i[0]; av = 1; ps = {8'($urandom), $urandom};
      step();
    end
    #3 rst_n = 0;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (got_v(c) !== '0)
        begin errors++; $display("FAIL async_reset[%0d] got %h want 0", c, got_v(c)); end
    end
    step();
    rst_n = 1; wl = 0; ws = 0; av = 0;
    step();
    checks++;
    if (o_pv[0] !== 1'b0 || o_ps[0] !== '0)
      begin errors++; $display("FAIL post_reset_idle got %h/%0b want 0/0", o_ps[0], o_pv[0]); end
    a = 16'd9; ps = '0; av = 1; step();
    av = 0;
    checks++;
    if (o_ps[0] !== '0 || o_pv[0] !== 1'b1)
      begin errors++; $display("FAIL post_reset_weight got %h/%0b want 0/1", o_ps[0], o_pv[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      wl  = $urandom_range(0, 1);
      ws  = ($urandom_range(0, 3) == 0);
      av  = ($urandom_range(0, 3) != 0);
      a   = WA'($urandom);
      w   = WB'($urandom);
      case ($urandom_range(0, 5))
        0: ps = 40'h7F_FFFF_FF00;
        1: ps = 40'h80_0000_00FF;
        2: ps = 40'hFF_FFFF_FF00;
        default: ps = {8'($urandom), $urandom};
      endcase
      step();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (got_v(c) !== exp_v(c))
          begin errors++; $display("FAIL random[%0d] cyc %0d got %h want %h", c, i, got_v(c), exp_v(c)); end
      end
    end
    en = 1; clr = 0; wl = 0; ws = 0; av = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_mac();
    test_double_buffer();
    test_saturation();
    test_unsigned();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
